// File: rtl/spectrum_avg_pkg.sv
// Shared types and helpers for the spectrum averager: accumulator sizing,
// {re,im} lane packing/unpacking and averaging-depth clamping.
package spectrum_avg_pkg;

    localparam int LANE_MAX_W = 64;

    typedef enum logic [1:0] {
        FK_FIRST,
        FK_MIDDLE,
        FK_FINAL,
        FK_SINGLE
    } frame_kind_e;

    function automatic int acc_w(input int data_w, input int max_log2_avg);
        return data_w + max_log2_avg;
    endfunction

    // Extract one lane (upper = re, lower = im) and sign-extend it to 64 bits.
    function automatic logic signed [LANE_MAX_W-1:0] lane_unpack(
        input logic [2*LANE_MAX_W-1:0] word,
        input int                      lane_w,
        input logic                    upper
    );
        logic [2*LANE_MAX_W-1:0]      shifted;
        logic signed [LANE_MAX_W-1:0] lane;
        shifted = upper ? (word >> lane_w) : word;
        lane    = shifted[LANE_MAX_W-1:0];
        lane    = lane <<< (LANE_MAX_W - lane_w);
        return lane >>> (LANE_MAX_W - lane_w);
    endfunction

    function automatic logic [2*LANE_MAX_W-1:0] lane_pack(
        input logic [LANE_MAX_W-1:0] re,
        input logic [LANE_MAX_W-1:0] im,
        input int                    lane_w
    );
        logic [LANE_MAX_W-1:0] mask;
        mask = {LANE_MAX_W{1'b1}} >> (LANE_MAX_W - lane_w);
        return ({{LANE_MAX_W{1'b0}}, re & mask} << lane_w) | {{LANE_MAX_W{1'b0}}, im & mask};
    endfunction

    function automatic int clamp_k(input int req, input int max_k);
        return (req > max_k) ? max_k : req;
    endfunction

endpackage

// File: rtl/spectrum_averager_avg_acc_ram.sv
// Per-bin accumulator storage: asynchronous read, synchronous write.
module avg_acc_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 54
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/spectrum_averager.sv
// Bin-by-bin averager over 2^k consecutive complex frames with rounding,
// valid/ready backpressure on the final frame and frame-alignment checking.
module spectrum_averager
    import spectrum_avg_pkg::*;
#(
    parameter int N_POINTS     = 128,
    parameter int DATA_W       = 24,
    parameter int MAX_LOG2_AVG = 3
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [$clog2(MAX_LOG2_AVG+1)-1:0] i_avg_log2,
    input  logic [2*DATA_W-1:0]               i_data,
    input  logic                              i_data_valid,
    input  logic                              i_data_last,
    output logic                              o_data_ready,
    output logic [2*DATA_W-1:0]               o_data,
    output logic                              o_data_valid,
    output logic                              o_data_last,
    input  logic                              i_data_ready,
    output logic                              o_frame_err
);

    localparam int ACC_W = acc_w(DATA_W, MAX_LOG2_AVG);
    localparam int BIN_W = $clog2(N_POINTS);
    localparam int KW    = $clog2(MAX_LOG2_AVG + 1);
    localparam int FW    = (MAX_LOG2_AVG > 0) ? MAX_LOG2_AVG : 1;

    logic [BIN_W-1:0]    bin_idx_q, bin_idx_d;
    logic [FW-1:0]       frame_idx_q, frame_idx_d;
    logic [KW-1:0]       k_act_q, k_act_d;
    logic [2*DATA_W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                frame_err_q, frame_err_d;

    logic [KW-1:0]       k_req;
    logic [FW:0]         set_len;
    logic                is_first, is_final, bin_last, misalign;
    logic                acc_in, emit, ready;
    frame_kind_e         kind;

    logic signed [ACC_W-1:0] smp_re, smp_im, mem_re, mem_im;
    logic signed [ACC_W-1:0] sum_re, sum_im, rnd, rsum_re, rsum_im;
    logic [2*ACC_W-1:0]      mem_rdata, mem_wdata;
    logic [2*DATA_W-1:0]     avg_word;
    logic                    mem_we;

    assign k_req = KW'(clamp_k(int'(i_avg_log2), MAX_LOG2_AVG));

    always_comb begin
        set_len  = (FW+1)'(1) << k_act_q;
        is_first = (frame_idx_q == '0);
        is_final = ({1'b0, frame_idx_q} == set_len - 1'b1);
        bin_last = (bin_idx_q == BIN_W'(N_POINTS - 1));
        misalign = i_data_last ^ bin_last;
        ready    = !is_final || !out_valid_q || i_data_ready;
        acc_in   = i_data_valid && ready;
        emit     = out_valid_q && i_data_ready;
        if (is_first && is_final) kind = FK_SINGLE;
        else if (is_first)        kind = FK_FIRST;
        else if (is_final)        kind = FK_FINAL;
        else                      kind = FK_MIDDLE;
    end

    // The first frame of a set adds to zero instead of memory, so stale
    // contents never need clearing.
    always_comb begin
        smp_re    = ACC_W'(lane_unpack(128'(i_data), DATA_W, 1'b1));
        smp_im    = ACC_W'(lane_unpack(128'(i_data), DATA_W, 1'b0));
        mem_re    = ACC_W'(lane_unpack(128'(mem_rdata), ACC_W, 1'b1));
        mem_im    = ACC_W'(lane_unpack(128'(mem_rdata), ACC_W, 1'b0));
        sum_re    = (is_first ? '0 : mem_re) + smp_re;
        sum_im    = (is_first ? '0 : mem_im) + smp_im;
        rnd       = (k_act_q == '0) ? '0 : (ACC_W'(1) << (k_act_q - 1'b1));
        rsum_re   = sum_re + rnd;
        rsum_im   = sum_im + rnd;
        avg_word  = (2*DATA_W)'(lane_pack(64'(rsum_re >>> k_act_q), 64'(rsum_im >>> k_act_q), DATA_W));
        mem_wdata = (2*ACC_W)'(lane_pack(64'(sum_re), 64'(sum_im), ACC_W));
    end

    always_comb begin
        bin_idx_d   = bin_idx_q;
        frame_idx_d = frame_idx_q;
        k_act_d     = k_act_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        if (emit) begin
            out_valid_d = 1'b0;
        end
        if (acc_in) begin
            if (misalign) begin
                frame_err_d = 1'b1;
                bin_idx_d   = '0;
                frame_idx_d = '0;
                k_act_d     = k_req;
            end else begin
                case (kind)
                    FK_FIRST, FK_MIDDLE: mem_we = 1'b1;
                    default: begin
                        out_valid_d = 1'b1;
                        out_data_d  = avg_word;
                        out_last_d  = bin_last;
                    end
                endcase
                if (bin_last) begin
                    bin_idx_d = '0;
                    if (is_final) begin
                        frame_idx_d = '0;
                        k_act_d     = k_req;
                    end else begin
                        frame_idx_d = frame_idx_q + 1'b1;
                    end
                end else begin
                    bin_idx_d = bin_idx_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_idx_q   <= '0;
            frame_idx_q <= '0;
            k_act_q     <= k_req;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bin_idx_q   <= bin_idx_d;
            frame_idx_q <= frame_idx_d;
            k_act_q     <= k_act_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    avg_acc_ram #(
        .DEPTH (N_POINTS),
        .WIDTH (2*ACC_W)
    ) u_acc_ram (
        .i_clk   (i_clk),
        .i_we    (mem_we),
        .i_waddr (bin_idx_q),
        .i_wdata (mem_wdata),
        .i_raddr (bin_idx_q),
        .o_rdata (mem_rdata)
    );

    assign o_data_ready = ready;
    assign o_data       = out_data_q;
    assign o_data_valid = out_valid_q;
    assign o_data_last  = out_last_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_spectrum_averager.sv
// Randomized bench for spectrum_averager against a frame-list averaging model.
module tb_spectrum_averager;

    localparam int N    = 8;
    localparam int DW   = 16;
    localparam int MAXK = 3;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [1:0]    i_avg_log2 = 2'd2;
    logic [31:0]   i_data = '0;
    logic          i_data_valid = 1'b0;
    logic          i_data_last = 1'b0;
    logic          i_data_ready = 1'b1;
    logic          o_data_ready;
    logic [31:0]   o_data;
    logic          o_data_valid;
    logic          o_data_last;
    logic          o_frame_err;

    always #5 i_clk = ~i_clk;

    spectrum_averager #(
        .N_POINTS     (N),
        .DATA_W       (DW),
        .MAX_LOG2_AVG (MAXK)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_avg_log2   (i_avg_log2),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .i_data_last  (i_data_last),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_data_last  (o_data_last),
        .i_data_ready (i_data_ready),
        .o_frame_err  (o_frame_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    int   n_chk = 0;
    int   n_pass = 0;
    int   m_bin, m_frame, m_k;
    int   m_re [N][N];
    int   m_im [N][N];
    exp_t exp_q [$];
    bit   err_next, lat_pending, prev_stall, taken, rnd_ready, stall_arm;
    logic [33:0] prev_word;
    logic [31:0] first_out;
    int   out_cnt, last_cnt, err_cnt, err_base, stall_left, stall_seen, gap_max;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int clampk(input int v);
        return (v > MAXK) ? MAXK : v;
    endfunction

    function automatic bit m_final();
        return m_frame == (1 << m_k) - 1;
    endfunction

    task automatic model_restart();
        m_bin   = 0;
        m_frame = 0;
        m_k     = clampk(int'(i_avg_log2));
    endtask

    // Average = round-half-up of the sum of this set's stored frames for the bin.
    task automatic model_accept();
        int re, im, sr, si, bias, er, ei;
        re    = $signed(i_data[31:16]);
        im    = $signed(i_data[15:0]);
        taken = 1'b1;
        if (i_data_last != (m_bin == N-1)) begin
            err_next = 1'b1;
            model_restart();
        end else begin
            m_re[m_frame][m_bin] = re;
            m_im[m_frame][m_bin] = im;
            if (m_final()) begin
                sr = 0;
                si = 0;
                for (int f = 0; f <= m_frame; f++) begin
                    sr += m_re[f][m_bin];
                    si += m_im[f][m_bin];
                end
                bias = (m_k > 0) ? (1 << (m_k - 1)) : 0;
                er   = (sr + bias) >>> m_k;
                ei   = (si + bias) >>> m_k;
                exp_q.push_back('{data: {er[15:0], ei[15:0]}, last: i_data_last});
                lat_pending = 1'b1;
            end
            if (i_data_last) begin
                if (m_final()) begin
                    m_frame = 0;
                    m_k     = clampk(int'(i_avg_log2));
                end else begin
                    m_frame++;
                end
                m_bin = 0;
            end else begin
                m_bin++;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        check("ready", o_data_ready, m_final() ? (!o_data_valid || i_data_ready) : 1'b1);
        check("frame_err", o_frame_err, err_next);
        if (o_frame_err) err_cnt++;
        err_next = 1'b0;
        if (lat_pending) check("latency", o_data_valid, 1'b1);
        lat_pending = 1'b0;
        if (prev_stall) check("hold", {o_data_valid, o_data_last, o_data}, prev_word);
        if (o_data_valid && i_data_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("data", o_data, e.data);
                check("last", o_data_last, e.last);
            end
            if (out_cnt == 0) first_out = o_data;
            out_cnt++;
            if (o_data_last) last_cnt++;
        end
        prev_stall = o_data_valid && !i_data_ready;
        if (prev_stall) stall_seen++;
        prev_word = {o_data_valid, o_data_last, o_data};
    endtask

    task automatic tick();
        @(negedge i_clk);
        monitor();
        if (!i_rst && i_data_valid && o_data_ready) model_accept();
        @(posedge i_clk);
        if (i_rst) begin
            model_restart();
            exp_q.delete();
            err_next    = 1'b0;
            lat_pending = 1'b0;
            prev_stall  = 1'b0;
        end
        #1;
        if (stall_arm && m_final() && m_bin == 3) begin
            stall_left = 3;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            i_data_ready = 1'b0;
            stall_left--;
        end else begin
            i_data_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic send_beat(input logic [15:0] re, input logic [15:0] im, input logic last);
        i_data       = {re, im};
        i_data_valid = 1'b1;
        i_data_last  = last;
        taken        = 1'b0;
        for (int w = 0; w < 200 && !taken; w++) tick();
        if (!taken) check("accept_timeout", 1'b0, 1'b1);
        i_data_valid = 1'b0;
        i_data_last  = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
    endtask

    task automatic send_const(input logic [15:0] re, input logic [15:0] im);
        for (int b = 0; b < N; b++) send_beat(re, im, b == N-1);
    endtask

    task automatic send_rand();
        for (int b = 0; b < N; b++) send_beat(16'($urandom), 16'($urandom), b == N-1);
    endtask

    task automatic send_bin0(input logic [15:0] re0, input logic [15:0] im0);
        send_beat(re0, im0, 1'b0);
        for (int b = 1; b < N; b++) send_beat(16'($urandom), 16'($urandom), b == N-1);
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        i_data_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        check("rst_valid", o_data_valid, 1'b0);
        check("rst_data", o_data, 32'h0);
        check("rst_last", o_data_last, 1'b0);
        check("rst_err", o_frame_err, 1'b0);
        check("rst_ready", o_data_ready, 1'b1);
    endtask

    task automatic begin_counts();
        out_cnt  = 0;
        last_cnt = 0;
        err_base = err_cnt;
    endtask

    task automatic end_test();
        repeat (6) tick();
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        err_cnt = 0; stall_left = 0; stall_seen = 0; gap_max = 0;
        rnd_ready = 1'b0; stall_arm = 1'b0;
        err_next = 1'b0; lat_pending = 1'b0; prev_stall = 1'b0;
        @(posedge i_clk);
        #1;
        model_restart();
        i_rst = 1'b0;
        do_reset();

        // k=2 constant frames: nothing until the final frame, then 8 beats.
        i_avg_log2 = 2'd2; do_reset(); begin_counts();
        repeat (3) send_const(16'd100, 16'hFF9C);
        check("t1_early_out", 64'(out_cnt), 64'd0);
        send_const(16'd100, 16'hFF9C);
        end_test();
        check("t1_cnt", 64'(out_cnt), 64'd8);
        check("t1_lastcnt", 64'(last_cnt), 64'd1);
        check("t1_value", first_out, {16'd100, 16'hFF9C});

        // Rounding on bin 0 and full-scale negative with k=3.
        i_avg_log2 = 2'd2; do_reset(); begin_counts();
        for (int f = 1; f <= 4; f++) send_bin0(16'(f), 16'(-f));
        end_test();
        check("t2_round", first_out, {16'd3, 16'hFFFE});
        i_avg_log2 = 2'd3; do_reset(); begin_counts();
        repeat (8) send_const(16'h8000, 16'h8000);
        end_test();
        check("t2_fullscale", first_out, {16'h8000, 16'h8000});
        check("t2_cnt", 64'(out_cnt), 64'd8);

        // k=1 with a 3-cycle downstream stall in the final frame.
        i_avg_log2 = 2'd1; do_reset(); begin_counts();
        stall_seen = 0; stall_arm = 1'b1;
        repeat (2) send_rand();
        end_test();
        check("t3_cnt", 64'(out_cnt), 64'd8);
        check("t3_lastcnt", 64'(last_cnt), 64'd1);
        check("t3_stalled", stall_seen >= 3, 1'b1);

        // Early last at bin 5 of frame 1, then a clean set.
        i_avg_log2 = 2'd2; do_reset(); begin_counts();
        send_rand();
        for (int b = 0; b < 6; b++) send_beat(16'($urandom), 16'($urandom), b == 5);
        repeat (3) tick();
        check("t4_err", 64'(err_cnt - err_base), 64'd1);
        check("t4_no_out", 64'(out_cnt), 64'd0);
        repeat (4) send_rand();
        end_test();
        check("t4_cnt", 64'(out_cnt), 64'd8);

        // Reset at bin 3 of the final frame, then a fresh set.
        i_avg_log2 = 2'd2; do_reset();
        repeat (3) send_rand();
        for (int b = 0; b < 4; b++) send_beat(16'($urandom), 16'($urandom), 1'b0);
        do_reset(); begin_counts();
        repeat (4) send_rand();
        end_test();
        check("t5_cnt", 64'(out_cnt), 64'd8);
        check("t5_lastcnt", 64'(last_cnt), 64'd1);

        // k changes 2 -> 0 inside frame 1; set completes with k=2.
        i_avg_log2 = 2'd2; do_reset(); begin_counts();
        send_rand();
        for (int b = 0; b < N; b++) begin
            if (b == 3) i_avg_log2 = 2'd0;
            send_beat(16'($urandom), 16'($urandom), b == N-1);
        end
        check("t6_mid_set", 64'(out_cnt), 64'd0);
        repeat (2) send_rand();
        repeat (2) send_rand();
        end_test();
        check("t6_cnt", 64'(out_cnt), 64'd24);
        check("t6_lastcnt", 64'(last_cnt), 64'd3);
        begin_counts();
        send_const(16'd123, 16'hFFFB);
        end_test();
        check("t6_passthru", first_out, {16'd123, 16'hFFFB});

        // Random k, gaps, backpressure and occasional misaligned frames.
        rnd_ready = 1'b1; gap_max = 2; begin_counts();
        for (int fr = 0; fr < 30; fr++) begin
            if ($urandom_range(0, 5) == 0) i_avg_log2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                int len;
                len = $urandom_range(1, N);
                for (int b = 0; b < len; b++)
                    send_beat(16'($urandom), 16'($urandom), (b == len-1) && (len < N));
            end else begin
                send_rand();
            end
        end
        rnd_ready = 1'b0; gap_max = 0;
        repeat (10) tick();
        check("rand_drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spectrum_averager.md
Name: spectrum_averager

Overview:
- Streaming frame averager for FFT output. Averages 2^k consecutive N-point complex frames bin by bin, with k selectable at run time.
- Emits one averaged N-point frame per averaging set.
- Sits between the FFT core and the output/DMA peripheral.
- Relative to the previous 4-frame fixed block, it adds separate re/im lanes with guard bits, rounding, a true valid/ready backpressure path, frame-boundary checking, and no memory-clear pass.

Parameters:
- N_POINTS, 128, frame length in bins. Power of two, ≥4.
- DATA_W, 24, width of each lane (re, im), signed two's complement.
- MAX_LOG2_AVG, 3, largest supported k. Maximum set size is 2^MAX_LOG2_AVG frames.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_avg_log2, in, $clog2(MAX_LOG2_AVG+1), requested k. Values above MAX_LOG2_AVG are clamped to MAX_LOG2_AVG.
- i_data, in, 2*DATA_W, input sample packed {re, im}.
- i_data_valid, in, 1, input sample valid.
- i_data_last, in, 1, marks the last bin of an input frame.
- o_data_ready, out, 1, block can accept an input sample.
- o_data, out, 2*DATA_W, averaged sample packed {re, im}.
- o_data_valid, out, 1, averaged sample valid.
- o_data_last, out, 1, marks the last bin of an averaged frame.
- i_data_ready, in, 1, downstream can accept an output sample.
- o_frame_err, out, 1, one-cycle pulse on a frame misalignment.

Behaviour:
- Accept: acc_in = i_data_valid & o_data_ready. Emit: o_data_valid & i_data_ready.
- Accumulator width: ACC_W = DATA_W + MAX_LOG2_AVG per lane. Storage: N_POINTS×(2*ACC_W), asynchronous read at bin_idx.
- State:
  - bin_idx runs 0..N_POINTS-1.
  - frame_idx runs 0..2^k-1.
  - k_act is latched from i_avg_log2 only when frame_idx returns to 0 (set boundary). It is also loaded on reset.
- Frame kinds:
  - first frame: frame_idx==0.
  - final frame: frame_idx==2^k_act-1.
  - With k_act=0, each frame is both first and final.
- First frame, accepted beat: write the sign-extended sample to memory. The old contents are ignored, so no clear pass is needed.
- Middle frame, accepted beat: write mem[bin_idx] + sample.
- Final frame, accepted beat:
  - Compute sum = mem + sample per lane.
  - Register o_data = (sum + 2^(k_act-1)) >>> k_act, truncated to DATA_W. With k_act=0 the output is sum unchanged.
  - Rounding is round-half-up. The result always fits DATA_W; no saturation logic.
  - Memory is not written.
- o_data_ready:
  - Constant 1 outside the final frame.
  - In the final frame: !o_data_valid | i_data_ready.
- Output register:
  - Set on a final-frame accept.
  - Cleared on emit with no new accept.
  - o_data, o_data_last and o_data_valid are held stable while o_data_valid & !i_data_ready.
  - Latency is 1 cycle from accept to o_data_valid. Full throughput of 1 sample/cycle under ready=1.
- Frame boundary on an accepted beat, when bin_idx==N_POINTS-1 and i_data_last=1:
  - bin_idx goes to 0.
  - frame_idx increments, or wraps to 0 at 2^k_act-1.
  - o_data_last=1 on the corresponding output beat.
- Misalignment: i_data_last=1 with bin_idx≠N_POINTS-1, or bin_idx==N_POINTS-1 with i_data_last=0.
  - The beat is consumed and dropped: no memory write, no output.
  - o_frame_err pulses for 1 cycle.
  - bin_idx and frame_idx go to 0, and k_act is relatched. The set is discarded.
  - Any partial averaged frame already emitted ends without o_data_last. Downstream treats this as an aborted frame.
- Reset, including mid-frame:
  - bin_idx=0, frame_idx=0, k_act=clamp(i_avg_log2).
  - o_data=0, o_data_valid=0, o_data_last=0, o_frame_err=0.
  - o_data_ready=1 from the first cycle after reset.
  - Memory is not cleared.
- i_data_valid low: no state change, except that the output register drains on emit.

Decomposition:
- Package spectrum_avg_pkg holds:
  - ACC_W function.
  - Lane pack/unpack functions ({re,im} slicing and sign extension).
  - The k-clamp function.
- Sub-module avg_acc_ram: parametrised N_POINTS×(2*ACC_W) memory with one asynchronous read port and one synchronous write port. This keeps the read-modify-write datapath separate from control.

Test Plan (N_POINTS=8, DATA_W=16, MAX_LOG2_AVG=3):
1. k=2, 4 frames all bins re=100, im=-100, ready=1:
   - No output during frames 0–2.
   - Frame 3 gives 8 outputs {100,-100}, 1-cycle latency.
   - o_data_last on the 8th output only.
2. k=2, bin0 re=1,2,3,4 and im=-1,-2,-3,-4 over the 4 frames:
   - Expected out {3,-2}, from (10+2)>>2 and (-10+2)>>>2.
   - k=3 with all frames re=im=-32768 gives {-32768,-32768}, no overflow.
3. k=1, i_data_ready low for 3 cycles mid-final-frame:
   - o_data_ready=0 and o_data stable while stalled.
   - All 8 outputs delivered in order, none lost or duplicated.
4. k=2, i_data_last at bin 5 of frame 1:
   - o_frame_err pulse; no output for that beat.
   - Next beat is treated as bin 0 of frame 0.
   - 4 clean frames afterwards yield a correct average.
5. i_rst for 1 cycle at bin 3 of the final frame:
   - All outputs 0, o_data_ready=1.
   - The following 4 frames average correctly, with no residue from the pre-reset set.
6. Change i_avg_log2 from 2 to 0 during frame 1:
   - The current set completes with k=2.
   - Subsequent frames pass through unchanged with 1-cycle latency, and o_data_last on every frame.
